// File: rtl/mux_stream_pkg.sv
// Shared definitions for stream multiplexers and arbiters: mode encodings
// and the rotated-priority search used by round-robin arbitration.
package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest arbiter the search function supports.
  localparam int MAX_N     = 16;
  localparam int MAX_SEL_W = 4;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr+1, wrapping back around to ptr itself.
  // n is the number of live channels; req bits at n and above are ignored.
  function automatic rr_pick_t rr_search(input logic [MAX_N-1:0]     req,
                                         input logic [MAX_SEL_W-1:0] ptr,
                                         input int                   n);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      if ((k <= n) && !r.found && (c < MAX_N) && req[c[MAX_SEL_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = c[MAX_SEL_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr,
// wrapping around. The pointer register lives in the instantiating block.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [MAX_N-1:0]     req_x;
  logic [MAX_SEL_W-1:0] ptr_x;
  rr_pick_t             pick;

  // Widen to the search function's fixed width, search, and gate by en.
  always_comb begin
    req_x            = '0;
    req_x[N-1:0]     = req;
    ptr_x            = '0;
    ptr_x[SEL_W-1:0] = ptr;
    pick             = rr_search(req_x, ptr_x, N);
    grant            = '0;
    grant_idx        = '0;
    grant_vld        = 1'b0;
    if (en && pick.found) begin
      grant_vld = 1'b1;
      grant_idx = pick.idx[SEL_W-1:0];
      grant     = N'(1) << pick.idx;
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration
// and a one-entry registered output stage with valid/ready handshakes.
module mux_nx1_stream
  import mux_stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  // Output register stage and arbitration pointer.
  logic             vld_p1;
  logic [W-1:0]     data_p1;
  logic [SEL_W-1:0] chan_p1;
  logic [SEL_W-1:0] ptr;

  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;

  logic [N-1:0]     fix_grant;
  logic [N-1:0]     grant_oh;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic [W-1:0]     grant_data;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_rr (
    .req       (in_valid),
    .ptr       (ptr),
    .en        (mode == MODE_RR),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  // Fixed-mode grant; an out-of-range sel matches no channel and never grants.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N; i++) begin
      if ((mode == MODE_FIXED) && (sel == SEL_W'(i)) && in_valid[i]) fix_grant[i] = 1'b1;
    end
  end

  // Merge the two grant sources and pick the winning channel's data.
  always_comb begin
    grant_oh   = (mode == MODE_RR) ? rr_grant : fix_grant;
    grant_idx  = (mode == MODE_RR) ? rr_idx : sel;
    grant_vld  = rr_vld | (|fix_grant);
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*W +: W];
    end
  end

  // Handshake: the output stage accepts when empty or draining this cycle.
  always_comb begin
    load_en  = !vld_p1 || out_ready;
    xfer     = rst_n && load_en && grant_vld;
    in_ready = (rst_n && load_en) ? grant_oh : '0;
  end

  // Output register and pointer; a reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr     <= SEL_W'(N - 1);
    end else if (load_en) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= grant_data;
        chan_p1 <= grant_idx;
        ptr     <= grant_idx;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: table vectors, hand sequences for reset,
// round-robin order and backpressure, a 3-channel instance for out-of-range
// select, and randomized traffic against a behavioural model.
module tb_mux_nx1_stream;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [23:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state: the word held at the output, and the last grant.
  logic       m_vld = 1'b0;
  logic [7:0] m_data = '0;
  int         m_chan = 0;
  int         m_ptr = NN - 1;

  always #5 clk = ~clk;

  mux_nx1_stream #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_stream #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Channel the spec's rules grant this cycle, or -1 when none.
  function automatic int pick();
    if (!rst_n) return -1;
    if (m_vld && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < NN && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= NN; k++) begin
      int c;
      c = (m_ptr + k) % NN;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model at the edge,
  // then check the registered outputs just after it.
  task automatic cycle(output logic [3:0] rdy_seen);
    int          g;
    logic [31:0] e;
    @(negedge clk);
    g = pick();
    e = (g >= 0) ? (32'd1 << g) : 32'd0;
    rdy_seen = in_ready;
    check("in_ready", {28'd0, in_ready}, e);
    @(posedge clk);
    if (!rst_n) begin
      m_vld = 1'b0; m_data = '0; m_chan = 0; m_ptr = NN - 1;
    end else if (!m_vld || out_ready) begin
      if (g >= 0) begin
        m_vld = 1'b1; m_data = in_data[g*8 +: 8]; m_chan = g; m_ptr = g;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    check("out_data", {24'd0, out_data}, {24'd0, m_data});
    check("out_chan", {30'd0, out_chan}, m_chan);
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ovld;
    logic [7:0] odata;
    logic [1:0] ochan;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0] r;
    logic [1:0] seq_a[8];
    logic [1:0] seq_b[4];

    // ch3=44 ch2=A5 ch1=22 ch0=11
    tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[2]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tbl[9]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[10] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
    tbl[11] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2};
    seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    seq_b = '{2'd1, 2'd3, 2'd1, 2'd3};

    // Reset held for three cycles with every input valid.
    rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = 32'h44A5_2211;
    for (int i = 0; i < 3; i++) begin
      cycle(r);
      check("rst_in_ready", {28'd0, r}, 32'd0);
    end
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_chan", {30'd0, out_chan}, 32'd0);
    rst_n = 1'b1;

    // Table vectors; row 0 is the first cycle after reset release.
    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
      cycle(r);
      check($sformatf("tbl%0d_ready", i), {28'd0, r}, {28'd0, tbl[i].rdy});
      check($sformatf("tbl%0d_ovld", i), {31'd0, out_valid}, {31'd0, tbl[i].ovld});
      check($sformatf("tbl%0d_odata", i), {24'd0, out_data}, {24'd0, tbl[i].odata});
      check($sformatf("tbl%0d_ochan", i), {30'd0, out_chan}, {30'd0, tbl[i].ochan});
    end

    // Reset mid-stream (ptr=2, word held); next grant must go to channel 0.
    rst_n = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    cycle(r);
    check("midrst_ready", {28'd0, r}, 32'd0);
    check("midrst_ovld", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(r);
      check($sformatf("rr_all_%0d", i), {30'd0, out_chan}, {30'd0, seq_a[i]});
      check($sformatf("rr_all_vld_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle(r);
      check($sformatf("rr_1010_%0d", i), {30'd0, out_chan}, {30'd0, seq_b[i]});
    end

    // Backpressure: 3C held for five stalled cycles, then drain and reload together.
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; in_data = 32'h44A5_223C;
    cycle(r);
    check("bp_load", {24'd0, out_data}, 32'h3C);
    out_ready = 1'b0; in_data = 32'h44A5_2200;
    for (int i = 0; i < 5; i++) begin
      cycle(r);
      check($sformatf("bp_ready_%0d", i), {28'd0, r}, 32'd0);
      check($sformatf("bp_data_%0d", i), {24'd0, out_data}, 32'h3C);
      check($sformatf("bp_vld_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1; in_data = 32'h44A5_2277;
    cycle(r);
    check("bp_release_ready", {28'd0, r}, 32'b0001);
    check("bp_release_data", {24'd0, out_data}, 32'h77);
    check("bp_release_vld", {31'd0, out_valid}, 32'd1);

    // Three-channel instance: sel=3 is out of range and must never grant.
    in_data3 = 24'h33_5A_11; in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd1; out_ready3 = 1'b1;
    @(negedge clk);
    check("n3_ready_sel1", {29'd0, in_ready3}, 32'b010);
    @(posedge clk); #1;
    check("n3_data_sel1", {24'd0, out_data3}, 32'h5A);
    check("n3_vld_sel1", {31'd0, out_valid3}, 32'd1);
    sel3 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("n3_oor_ready_%0d", i), {29'd0, in_ready3}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("n3_oor_vld_%0d", i), {31'd0, out_valid3}, 32'd0);
      check($sformatf("n3_oor_hold_%0d", i), {24'd0, out_data3}, 32'h5A);
    end
    in_valid3 = '0;

    // Randomized traffic against the model (model was kept in step above).
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      cycle(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nx1_stream.md
# mux_nx1_stream

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the team's 4:1 bit multiplexers. It adds three things: arbitrary width and channel count, a selectable fixed-select or round-robin arbitration mode, and a one-entry registered output stage. It sits between multiple producer streams and a single consumer, for example several UART/peripheral sources feeding one shared bus or FIFO.

## Interface
Parameters:
- N, default 4: number of input channels; legal range 2..16.
- W, default 8: data width per channel; minimum 1.
- SEL_W, default $clog2(N): select/index width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all logic on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  W  registered output data.
- out_chan  output  SEL_W  index of the channel whose data is in out_data.
- out_valid  output  1  output register holds a valid word.
- out_ready  input  1  consumer ready.

## Operation
- load_en = !out_valid || out_ready. When it is high, the output register may accept a new word this cycle.
- Grant selection is combinational each cycle:
  - Fixed mode (mode=0): grant = sel, provided sel < N and in_valid[sel]=1. Otherwise there is no grant. An out-of-range sel never grants and never asserts any in_ready.
  - Round-robin mode (mode=1): grant = first i with in_valid[i]=1, searching from (ptr+1) mod N upward with wrap to ptr. No valid input means no grant.
- in_ready[i] = load_en && (grant == i). in_ready is combinational from out_ready, in_valid, mode, sel and ptr.
- Input transfer: in_valid[i] && in_ready[i]. On the next edge, out_data <= channel i data, out_chan <= i, out_valid <= 1.
- load_en=1 with no grant: out_valid <= 0 on the next edge. out_data and out_chan hold their last values.
- Output transfer: out_valid && out_ready. This happens in the same cycle as a new input transfer where applicable, giving back-to-back operation.
- ptr (SEL_W bits): updated to the granted index on every input transfer, in either mode. ptr is retained across mode changes.
- mode and sel are sampled every cycle with no registering. A change affects the grant in the same cycle and never disturbs a word already held in the output register.
- While out_valid && !out_ready, out_data and out_chan are held stable and all in_ready bits are 0.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_chan=0, ptr=N-1. With ptr=N-1, the first round-robin search starts at channel 0. in_ready is all zero while rst_n=0.
- Reset mid-operation: a held output word is discarded. No input transfer occurs in a reset cycle.
- Latency: an input transfer at edge k appears on out_data/out_valid after edge k.
- Throughput: one word per clock when out_ready is held at 1.
- Round-robin fairness: with all N inputs continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.
- Simultaneous events:
  - An output drain and an input load in the same cycle are legal.
  - A word is never lost or duplicated.
  - Wrap-around: ptr=N-1 searches starting at channel 0.

## Structure
- Package mux_stream_pkg: MODE_FIXED=1'b0 and MODE_RR=1'b1 constants, plus a function for the rotated priority search, shared with future arbiters.
- Sub-module rr_arbiter #(N): inputs req[N-1:0], ptr and en; outputs a one-hot grant, grant_idx and grant_vld. It is purely combinational. ptr stays in mux_nx1_stream.
- Top level contains: fixed/round-robin grant selection, in_ready generation, the output register and the ptr register.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0. In the first cycle after release with mode=1, in_ready=4'b0001.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data channel 2 = 8'hA5, out_ready=1 → in_ready=4'b0100, and the next cycle out_data=8'hA5, out_chan=2. With sel=2 and in_valid[2]=0 → no grant, out_valid drops.
- Round-robin: mode=1, all valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: a word 8'h3C is held while out_ready=0 for 5 cycles → out_data stays 8'h3C, out_valid stays 1, in_ready stays 0. When out_ready=1, the drain and the next load happen in the same cycle.
- Out-of-range select: N=3, sel=3 in fixed mode → in_ready=0, out_valid=0 after draining.
- Reset mid-stream: round-robin running with ptr=2, assert rst_n=0 for one cycle → out_valid=0, and the next grant goes to channel 0.
